ledger_writeback: RTL and testbench
===================================

// Module: ledger_writeback
// PURPOSE
//  Write-side counterpart of the transaction datapath: commits the two updated, tagged player balances
//  (tag 101 = player 1, tag 110 = player 2) back into ledger memory once a transaction completes.
//  Sits between the datapath's balance outputs and the shared ledger RAM; signals completion to the control FSM.
//  Word format everywhere: [10:8] tag, [7:0] balance.
// PARAMETERS
//  ADDR_W     5       ledger RAM address width
//  P1_ADDR    5'd5    RAM address of player-1 balance word
//  P2_ADDR    5'd6    RAM address of player-2 balance word
//  COUNT_W    8       width of committed-transaction counter
//  MAX_RETRY  2       write retries per word on readback mismatch (used only with READBACK_VERIFY_EN)
// PORTS
//  clock      in   1        system clock, all logic on rising edge
//  reset      in   1        synchronous, active-high reset
//  start      in   1        request commit; sampled only in IDLE
//  p1_word    in   11       tagged player-1 balance to commit
//  p2_word    in   11       tagged player-2 balance to commit
//  mem_rdata  in   11       RAM read data, valid 1 cycle after address (used only with READBACK_VERIFY_EN)
//  mem_addr   out  ADDR_W   RAM address
//  mem_wdata  out  11       RAM write data
//  mem_wren   out  1        RAM write enable
//  busy       out  1        high in every state except IDLE
//  done       out  1        1-cycle pulse: both words committed
//  error      out  1        1-cycle pulse: commit aborted
//  txn_count  out  COUNT_W  number of successful commits, wraps to 0 after all-ones
// BEHAVIOUR
//  - Reset: state=IDLE; mem_addr=0, mem_wdata=0, mem_wren=0, busy=0, done=0, error=0, txn_count=0.
//    Reset wins over start in the same cycle. Reset mid-sequence aborts next edge; words already written stay written; no done/error.
//  - All outputs registered. In IDLE, start=1 captures p1_word/p2_word into internal regs; inputs are don't-care afterwards.
//  - Tag check on capture: p1_word[10:8]!=3'b101 or p2_word[10:8]!=3'b110 -> state ERR, no write ever issued.
//  - States: IDLE -> WR_P1 -> WR_P2 -> FIN -> IDLE; any -> ERR -> IDLE.
//    WR_P1: mem_wren=1, mem_addr=P1_ADDR, mem_wdata=p1 reg (exactly one cycle).
//    WR_P2: same with P2_ADDR / p2 reg.
//    FIN:   mem_wren=0, done=1, txn_count+=1 (modulo 2^COUNT_W).
//    ERR:   mem_wren=0, error=1, txn_count unchanged.
//  - Latency, start at edge N: P1 write visible N+1, P2 write N+2, done N+3; back in IDLE N+4, new start accepted then.
//  - start while busy is ignored (not queued). done and error never assert together.
//  - mem_wren low in every state except write states; mem_addr/mem_wdata hold last value when idle.
// CONFIGURATION
//  READBACK_VERIFY_EN defined:
//    - Each write state is followed by RD (wren=0, same addr) then CMP (compare mem_rdata with written word).
//    - Match -> next word / FIN. Mismatch -> rewrite same word; per-word retry counter resets on each new word.
//    - More than MAX_RETRY mismatches on one word -> ERR.
//    - No-fault latency: done at N+7.
//  READBACK_VERIFY_EN undefined: mem_rdata unused; no RD/CMP states; latency as above.
// TESTING
//  1. Reset, then start with p1=11'h50A, p2=11'h614 -> writes (5,0x50A) @N+1, (6,0x614) @N+2, done @N+3, txn_count=1.
//  2. start with p1=11'h30A (bad tag) -> error @N+1, mem_wren never high, txn_count unchanged.
//  3. start pulsed again at N+1..N+3 of a commit -> ignored; exactly 2 writes, 1 done.
//  4. reset asserted at N+2 (during WR_P2) -> all outputs reset @N+3, no done, txn_count=0.
//  5. Preload txn_count to all-ones via 2^COUNT_W-1 commits, one more commit -> txn_count=0 with done.
//  6. READBACK_VERIFY_EN, RAM model corrupts first P1 write -> P1 rewritten once, done @N+10; corrupt 3 times -> error.

Source files
------------

// File: rtl/ledger_writeback.sv
// ledger_writeback
//   Commits the two tagged player balances produced by the transaction
//   datapath back into the shared ledger RAM once a transaction completes,
//   then reports completion (done) or abort (error) to the control FSM.
//   Word format: [10:8] tag (101 = player 1, 110 = player 2), [7:0] balance.
//
//   Sequence: IDLE -> WR_P1 -> WR_P2 -> FIN -> IDLE, or IDLE -> ERR -> IDLE
//   when a captured tag is wrong. Every output is a register loaded from the
//   next-state decode, so the outputs always describe the current state.
//
//   Optional feature macro: READBACK_VERIFY_EN
//     When defined, every write is followed by a read (RD) and a compare (CMP)
//     of mem_rdata against the written word. A mismatch rewrites the same word.
//     More than MAX_RETRY mismatches on one word aborts through ERR.
//     When undefined, mem_rdata is ignored.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   commit request, sampled only in IDLE
//   p1_word    in   tagged player-1 balance
//   p2_word    in   tagged player-2 balance
//   mem_rdata  in   RAM read data, valid one cycle after the address
//   mem_addr   out  RAM address (holds last value when idle)
//   mem_wdata  out  RAM write data (holds last value when idle)
//   mem_wren   out  RAM write enable, high only in write states
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse, both words committed
//   error      out  one-cycle pulse, commit aborted
//   txn_count  out  successful commits, wraps modulo 2^COUNT_W
module ledger_writeback #(
  parameter int                ADDR_W    = 5,
  parameter logic [ADDR_W-1:0] P1_ADDR   = 5'd5,
  parameter logic [ADDR_W-1:0] P2_ADDR   = 5'd6,
  parameter int                COUNT_W   = 8,
  parameter int                MAX_RETRY = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [10:0]        p1_word,
  input  logic [10:0]        p2_word,
  input  logic [10:0]        mem_rdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [10:0]        mem_wdata,
  output logic               mem_wren,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [COUNT_W-1:0] txn_count
);

  localparam logic [2:0] P1_TAG = 3'b101;
  localparam logic [2:0] P2_TAG = 3'b110;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WR_P1  = 4'd1,
    S_RD_P1  = 4'd2,
    S_CMP_P1 = 4'd3,
    S_WR_P2  = 4'd4,
    S_RD_P2  = 4'd5,
    S_CMP_P2 = 4'd6,
    S_FIN    = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  // Both captured words must carry their own player's tag.
  function automatic logic tags_ok(input logic [10:0] w1, input logic [10:0] w2);
    return (w1[10:8] == P1_TAG) && (w2[10:8] == P2_TAG);
  endfunction

  state_t              state_r;
  state_t              next_state_s;
  logic [10:0]         p1_r;
  logic [10:0]         p2_r;
  logic [10:0]         p1_src_s;
  logic                wren_next_s;
  logic [ADDR_W-1:0]   addr_next_s;
  logic [10:0]         wdata_next_s;

`ifdef READBACK_VERIFY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0]  retry_r;
  logic [RETRY_W-1:0]  retry_next_s;
`else
  logic                unused_rdata_s;
  assign unused_rdata_s = ^mem_rdata;
`endif

  // The P1 write is launched on the same edge that captures p1_word, so the
  // live input is used when leaving IDLE and the captured copy afterwards.
  always_comb begin
    if (state_r == S_IDLE) begin
      p1_src_s = p1_word;
    end else begin
      p1_src_s = p1_r;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
`ifdef READBACK_VERIFY_EN
    retry_next_s = retry_r;
`endif
    case (state_r)
      S_IDLE: begin
`ifdef READBACK_VERIFY_EN
        retry_next_s = '0;
`endif
        if (start) begin
          if (tags_ok(p1_word, p2_word)) begin
            next_state_s = S_WR_P1;
          end else begin
            next_state_s = S_ERR;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
`ifdef READBACK_VERIFY_EN
      S_WR_P1:  next_state_s = S_RD_P1;
      S_RD_P1:  next_state_s = S_CMP_P1;
      S_CMP_P1: begin
        if (mem_rdata == p1_r) begin
          next_state_s = S_WR_P2;
          retry_next_s = '0;
        end else if (retry_r >= RETRY_W'(MAX_RETRY)) begin
          next_state_s = S_ERR;
        end else begin
          next_state_s = S_WR_P1;
          retry_next_s = retry_r + RETRY_W'(1);
        end
      end
      S_WR_P2:  next_state_s = S_RD_P2;
      S_RD_P2:  next_state_s = S_CMP_P2;
      S_CMP_P2: begin
        if (mem_rdata == p2_r) begin
          next_state_s = S_FIN;
        end else if (retry_r >= RETRY_W'(MAX_RETRY)) begin
          next_state_s = S_ERR;
        end else begin
          next_state_s = S_WR_P2;
          retry_next_s = retry_r + RETRY_W'(1);
        end
      end
`else
      S_WR_P1:  next_state_s = S_WR_P2;
      S_WR_P2:  next_state_s = S_FIN;
`endif
      S_FIN:    next_state_s = S_IDLE;
      S_ERR:    next_state_s = S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // RAM-side values for the state being entered; address and data hold
  // outside the write/readback states.
  always_comb begin
    wren_next_s  = 1'b0;
    addr_next_s  = mem_addr;
    wdata_next_s = mem_wdata;
    case (next_state_s)
      S_WR_P1: begin
        wren_next_s  = 1'b1;
        addr_next_s  = P1_ADDR;
        wdata_next_s = p1_src_s;
      end
      S_RD_P1, S_CMP_P1: addr_next_s = P1_ADDR;
      S_WR_P2: begin
        wren_next_s  = 1'b1;
        addr_next_s  = P2_ADDR;
        wdata_next_s = p2_r;
      end
      S_RD_P2, S_CMP_P2: addr_next_s = P2_ADDR;
      default: begin
        wren_next_s  = 1'b0;
        addr_next_s  = mem_addr;
        wdata_next_s = mem_wdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

`ifdef READBACK_VERIFY_EN
  // Per-word mismatch counter, cleared whenever a new word is started.
  always_ff @(posedge clock) begin
    if (reset) begin
      retry_r <= '0;
    end else begin
      retry_r <= retry_next_s;
    end
  end
`endif

  // Capture both words on an accepted start; inputs are ignored afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      p1_r <= 11'd0;
      p2_r <= 11'd0;
    end else if ((state_r == S_IDLE) && start) begin
      p1_r <= p1_word;
      p2_r <= p2_word;
    end else begin
      p1_r <= p1_r;
      p2_r <= p2_r;
    end
  end

  // Registered outputs, loaded from the next-state decode.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_wren  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 11'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      txn_count <= '0;
    end else begin
      mem_wren  <= wren_next_s;
      mem_addr  <= addr_next_s;
      mem_wdata <= wdata_next_s;
      busy      <= (next_state_s != S_IDLE);
      done      <= (next_state_s == S_FIN);
      error     <= (next_state_s == S_ERR);
      if (next_state_s == S_FIN) begin
        txn_count <= txn_count + COUNT_W'(1);
      end else begin
        txn_count <= txn_count;
      end
    end
  end

endmodule

// File: tb/tb_ledger_writeback.sv
// Self-checking bench for ledger_writeback. The reference model turns each
// accepted commit into a schedule of expected per-cycle output records held
// in a queue; the bench also models the ledger RAM (one-cycle read latency,
// optional write corruption for the readback-verify build).
module tb_ledger_writeback;

  localparam int ADDR_W    = 5;
  localparam int COUNT_W   = 8;
  localparam int MAX_RETRY = 2;
  localparam logic [4:0] A1 = 5'd5;
  localparam logic [4:0] A2 = 5'd6;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [10:0]        p1_word;
  logic [10:0]        p2_word;
  logic [10:0]        mem_rdata;
  logic [ADDR_W-1:0]  mem_addr;
  logic [10:0]        mem_wdata;
  logic               mem_wren;
  logic               busy;
  logic               done;
  logic               error;
  logic [COUNT_W-1:0] txn_count;

  always #5 clock = ~clock;

  ledger_writeback #(
    .ADDR_W(ADDR_W), .P1_ADDR(A1), .P2_ADDR(A2), .COUNT_W(COUNT_W), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .p1_word(p1_word), .p2_word(p2_word),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .busy(busy), .done(done), .error(error), .txn_count(txn_count)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        error;
    logic        wren;
    logic [4:0]  addr;
    logic [10:0] wdata;
  } rec_t;

  rec_t               exp_q[$];
  rec_t               cur;
  logic [COUNT_W-1:0] exp_count;
  int                 total = 0;
  int                 bad = 0;
  int                 commits = 0;
  int                 obs_writes = 0;
  int                 obs_dones = 0;
  int                 lat;
  logic [10:0]        ram [0:31];
  logic [4:0]         prev_addr;
  int                 corrupt_left [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic rec_t mk(input logic b, input logic d, input logic e, input logic w,
                              input logic [4:0] a, input logic [10:0] wd);
    rec_t r;
    r.busy = b; r.done = d; r.error = e; r.wren = w; r.addr = a; r.wdata = wd;
    return r;
  endfunction

  // Expected records for committing one word; ok=0 when the word aborts.
  task automatic plan_word(input logic [4:0] a, input logic [10:0] w, input int c, output logic ok);
`ifdef READBACK_VERIFY_EN
    int nfail;
    nfail = (c > MAX_RETRY) ? MAX_RETRY + 1 : c;
    for (int i = 0; i < nfail; i++) begin
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, a, w));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, a, w));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, a, w));
    end
    if (c > MAX_RETRY) begin
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, a, w));
      ok = 1'b0;
    end else begin
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, a, w));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, a, w));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, a, w));
      ok = 1'b1;
    end
`else
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, a, w));
    ok = (c >= 0);
`endif
  endtask

  task automatic plan_commit(input logic [10:0] w1, input logic [10:0] w2);
    logic ok;
    if (w1[10:8] != 3'b101 || w2[10:8] != 3'b110) begin
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, cur.addr, cur.wdata));
    end else begin
      plan_word(A1, w1, corrupt_left[0], ok);
      if (ok) begin
        plan_word(A2, w2, corrupt_left[1], ok);
        if (ok) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, A2, w2));
      end
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare #1 later.
  task automatic step(input string tag, input logic st, input logic [10:0] w1,
                      input logic [10:0] w2, input logic rst);
    start = st; p1_word = w1; p2_word = w2; reset = rst;
    @(posedge clock);
    if (rst) begin
      exp_q.delete();
      cur = '0;
      exp_count = '0;
      commits = 0;
    end else begin
      if (!cur.busy && st) plan_commit(w1, w2);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = mk(1'b0, 1'b0, 1'b0, 1'b0, cur.addr, cur.wdata);
      if (cur.done) begin
        exp_count = exp_count + 8'd1;
        commits++;
      end
    end
    #1;
    obs_writes += int'(mem_wren);
    obs_dones  += int'(done);
    check_eq({tag, "_outs"}, 32'({busy, done, error, mem_wren, mem_addr, mem_wdata}), 32'(cur));
    check_eq({tag, "_count"}, 32'(txn_count), 32'(exp_count));
  endtask

  // Ledger RAM model: write during the cycle, read data one cycle after address.
  initial begin
    forever begin
      @(negedge clock);
      mem_rdata = ram[prev_addr];
      if (mem_wren === 1'b1) begin
        if (mem_addr == A1 && corrupt_left[0] > 0) begin
          ram[mem_addr] = mem_wdata ^ 11'h001;
          corrupt_left[0]--;
        end else if (mem_addr == A2 && corrupt_left[1] > 0) begin
          ram[mem_addr] = mem_wdata ^ 11'h001;
          corrupt_left[1]--;
        end else begin
          ram[mem_addr] = mem_wdata;
        end
      end
      prev_addr = mem_addr;
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; p1_word = 11'd0; p2_word = 11'd0; mem_rdata = 11'd0;
    prev_addr = 5'd0; corrupt_left[0] = 0; corrupt_left[1] = 0;
    cur = '0; exp_count = '0;
    foreach (ram[i]) ram[i] = 11'd0;

    // Reset state
    step("rst", 1'b1, 11'h50A, 11'h614, 1'b1);
    step("rst", 1'b0, 11'd0, 11'd0, 1'b1);

    // Basic commit and its latency
    step("t1", 1'b1, 11'h50A, 11'h614, 1'b0);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      step("t1", 1'b0, 11'd0, 11'd0, 1'b0);
      lat++;
    end
`ifdef READBACK_VERIFY_EN
    check_eq("t1_latency", 32'(lat), 32'd7);
`else
    check_eq("t1_latency", 32'(lat), 32'd3);
`endif
    check_eq("t1_txn", 32'(txn_count), 32'd1);
    step("t1", 1'b0, 11'd0, 11'd0, 1'b0);
    check_eq("t1_ram_p1", 32'(ram[5]), 32'h50A);
    check_eq("t1_ram_p2", 32'(ram[6]), 32'h614);

    // Bad tag aborts without writing
    obs_writes = 0;
    step("t2", 1'b1, 11'h30A, 11'h614, 1'b0);
    check_eq("t2_error", 32'(error), 32'd1);
    for (int i = 0; i < 3; i++) step("t2", 1'b0, 11'd0, 11'd0, 1'b0);
    check_eq("t2_writes", 32'(obs_writes), 32'd0);

    // start pulses while busy are ignored
    obs_writes = 0; obs_dones = 0;
    step("t3", 1'b1, 11'h5AA, 11'h655, 1'b0);
`ifdef READBACK_VERIFY_EN
    for (int i = 0; i < 6; i++) step("t3", 1'b1, 11'h5BB, 11'h666, 1'b0);
`else
    for (int i = 0; i < 3; i++) step("t3", 1'b1, 11'h5BB, 11'h666, 1'b0);
`endif
    for (int i = 0; i < 2; i++) step("t3", 1'b0, 11'd0, 11'd0, 1'b0);
    check_eq("t3_writes", 32'(obs_writes), 32'd2);
    check_eq("t3_dones", 32'(obs_dones), 32'd1);

    // Reset in the middle of a commit
    step("t4", 1'b1, 11'h511, 11'h622, 1'b0);
    step("t4", 1'b0, 11'd0, 11'd0, 1'b0);
    step("t4", 1'b0, 11'd0, 11'd0, 1'b1);
    check_eq("t4_reset", 32'({busy, done, error, mem_wren, txn_count}), 32'd0);
    step("t4", 1'b0, 11'd0, 11'd0, 1'b0);

    // Counter wrap after 2^COUNT_W commits
    for (int i = 0; i < 2200 && commits < 256; i++)
      step("t5", 1'b1, {3'b101, 8'($urandom)}, {3'b110, 8'($urandom)}, 1'b0);
    check_eq("t5_commits", 32'(commits), 32'd256);
    check_eq("t5_wrap", 32'({done, txn_count}), 32'h100);
    for (int i = 0; i < 8; i++) step("t5", 1'b0, 11'd0, 11'd0, 1'b0);

`ifdef READBACK_VERIFY_EN
    // One corrupted P1 write: single rewrite, done three cycles later
    corrupt_left[0] = 1;
    step("t6", 1'b1, 11'h5C3, 11'h63C, 1'b0);
    lat = 1;
    while (done !== 1'b1 && error !== 1'b1 && lat < 30) begin
      step("t6", 1'b0, 11'd0, 11'd0, 1'b0);
      lat++;
    end
    check_eq("t6_retry_latency", 32'(lat), 32'd10);
    check_eq("t6_retry_done", 32'({done, error}), 32'h2);
    step("t6", 1'b0, 11'd0, 11'd0, 1'b0);
    // Three corrupted P1 writes: abort
    corrupt_left[0] = 3;
    step("t6", 1'b1, 11'h5C4, 11'h63D, 1'b0);
    lat = 1;
    while (done !== 1'b1 && error !== 1'b1 && lat < 30) begin
      step("t6", 1'b0, 11'd0, 11'd0, 1'b0);
      lat++;
    end
    check_eq("t6_abort_latency", 32'(lat), 32'd10);
    check_eq("t6_abort_error", 32'({done, error}), 32'h1);
    for (int i = 0; i < 2; i++) step("t6", 1'b0, 11'd0, 11'd0, 1'b0);
`endif

    // Randomized traffic with occasional bad tags and resets
    for (int i = 0; i < 600; i++) begin
      logic [2:0] t1;
      logic [2:0] t2;
      t1 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b101;
      t2 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b110;
      step("rnd", ($urandom_range(0, 2) == 0), {t1, 8'($urandom)}, {t2, 8'($urandom)},
           ($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 10; i++) step("end", 1'b0, 11'd0, 11'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
